// File: rtl/pwm_ramp_controller.sv
// Duty-cycle ramp controller: walks a registered duty value toward an accepted
// target one STEP per PWM period, with a stop request that ramps down to zero.
module pwm_ramp_controller #(
    parameter int unsigned PERIOD = 100,
    parameter int unsigned STEP   = 1,
    parameter int unsigned DMAX   = 101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    input  logic [31:0] tgt_duty,
    input  logic        stop,
    output logic [31:0] duty,
    output logic        busy,
    output logic        done,
    output logic        period_tick
);

    localparam int unsigned CNT_W  = (PERIOD < 1) ? 1 : $clog2(PERIOD + 1);
    localparam int unsigned DUTY_W = 32;
    localparam int unsigned WIDE_W = DUTY_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                tick_nx;
    logic [DUTY_W-1:0]   target;
    logic [DUTY_W-1:0]   target_nx;
    logic [DUTY_W-1:0]   duty_nx;
    logic [DUTY_W-1:0]   stepped;
    logic [DUTY_W-1:0]   clamped;
    logic                done_nx;
    logic [WIDE_W-1:0]   up;
    logic [WIDE_W-1:0]   dn;
    logic [WIDE_W-1:0]   target_wide;

    // Ready is combinational so a stop in the same cycle blocks the handshake.
    assign tgt_ready = rst && (state == IDLE) && !stop;

    // Free-running period counter; the tick flag is registered against the next count.
    always_comb begin
        cnt_nx  = (cnt == CNT_W'(PERIOD)) ? '0 : cnt + CNT_W'(1);
        tick_nx = (cnt_nx == CNT_W'(PERIOD));
    end

    assign clamped = (tgt_duty > DUTY_W'(DMAX)) ? DUTY_W'(DMAX) : tgt_duty;

    // One step toward target, widened so neither direction can wrap past it.
    always_comb begin
        target_wide = {1'b0, target};
        up          = {1'b0, duty} + WIDE_W'(STEP);
        dn          = {1'b0, duty} - WIDE_W'(STEP);
        stepped     = duty;
        if (duty < target) begin
            stepped = (up >= target_wide) ? target : up[DUTY_W-1:0];
        end else if (duty > target) begin
            stepped = (dn[WIDE_W-1] || (dn < target_wide)) ? target : dn[DUTY_W-1:0];
        end
    end

    // Next-state and datapath updates; STOP reuses the stepper with target forced to 0.
    always_comb begin
        state_nx  = state;
        target_nx = target;
        duty_nx   = duty;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (stop) begin
                    target_nx = '0;
                    state_nx  = STOP;
                end else if (tgt_valid) begin
                    target_nx = clamped;
                    state_nx  = RAMP;
                end
            end
            RAMP: begin
                if (stop) begin
                    target_nx = '0;
                    state_nx  = STOP;
                end else if (period_tick) begin
                    duty_nx = stepped;
                    if (stepped == target) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            STOP: begin
                if (period_tick) begin
                    duty_nx = stepped;
                    if (stepped == '0) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx  = IDLE;
                target_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            period_tick <= 1'b0;
            target      <= '0;
            duty        <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            period_tick <= tick_nx;
            target      <= target_nx;
            duty        <= duty_nx;
            done        <= done_nx;
            busy        <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller at default parameters.
module tb_pwm_ramp_controller;

    localparam int unsigned PERIOD = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [31:0] tgt_duty;
    logic        stop;
    logic [31:0] duty;
    logic        busy;
    logic        done;
    logic        period_tick;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_tick = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_ramp_controller dut (
        .clk(clk),
        .rst(rst),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .tgt_duty(tgt_duty),
        .stop(stop),
        .duty(duty),
        .busy(busy),
        .done(done),
        .period_tick(period_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for the next tick, then checks the duty/done/busy that follow it.
    task automatic step(input string tag, input int exp, input bit last, input bit gap);
        int n = 0;
        while (period_tick !== 1'b1 && n < int'(PERIOD) + 3) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_tick"}, 32'(period_tick), 32'd1);
        if (period_tick !== 1'b1) return;
        if (gap && last_tick >= 0) chk({tag, "_gap"}, 32'(cyc - last_tick), 32'(PERIOD + 1));
        last_tick = cyc;
        @(negedge clk);
        chk({tag, "_duty"}, duty, 32'(exp));
        chk({tag, "_done"}, 32'(done), 32'(last));
        chk({tag, "_busy"}, 32'(busy), 32'(!last));
        if (last) begin
            @(negedge clk);
            chk({tag, "_done_end"}, 32'(done), 32'd0);
            chk({tag, "_ready_end"}, 32'(tgt_ready), 32'd1);
        end
    endtask

    task automatic hs(input int v);
        last_tick = -1;
        tgt_duty  = 32'(v);
        tgt_valid = 1'b1;
        #1;
        chk("hs_ready", 32'(tgt_ready), 32'd1);
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("hs_busy", 32'(busy), 32'd1);
        chk("hs_no_done", 32'(done), 32'd0);
    endtask

    task automatic count_to_tick(input string tag);
        int n = 0;
        while (period_tick !== 1'b1 && n < int'(PERIOD) + 3) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n), 32'(PERIOD));
    endtask

    initial begin
        rst = 1'b0; stop = 1'b0; tgt_valid = 1'b0; tgt_duty = '0;
        repeat (3) @(negedge clk);
        chk("rst_duty", duty, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        chk("rst_ready", 32'(tgt_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(tgt_ready), 32'd1);
        count_to_tick("rel_cnt");

        // Handshake on a tick edge with target equal to duty.
        hs(0);
        step("eq", 0, 1'b1, 1'b0);

        hs(5);
        for (int d = 1; d <= 5; d++) step("up5", d, d == 5, 1'b1);

        hs(500);
        for (int d = 6; d <= 101; d++) step("clamp", d, d == 101, 1'b1);

        hs(10);
        for (int d = 100; d >= 10; d--) step("down10", d, d == 10, 1'b1);

        hs(7);
        for (int d = 9; d >= 7; d--) step("down7", d, d == 7, 1'b1);

        // Stop from IDLE at duty 7; a repeated stop in STOP changes nothing.
        stop = 1'b1;
        #1;
        chk("stop_ready", 32'(tgt_ready), 32'd0);
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd1);
        step("stopi", 6, 1'b0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop2_busy", 32'(busy), 32'd1);
        chk("stop2_duty", duty, 32'd6);
        for (int d = 5; d >= 0; d--) step("stopi", d, d == 0, 1'b1);

        hs(50);
        for (int d = 1; d <= 3; d++) step("to50", d, 1'b0, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stopr_busy", 32'(busy), 32'd1);
        chk("stopr_duty", duty, 32'd3);
        for (int d = 2; d >= 0; d--) step("stopr", d, d == 0, 1'b1);

        // Stop and valid together: no handshake, immediate stop completion.
        stop = 1'b1; tgt_valid = 1'b1; tgt_duty = 32'd20;
        #1;
        chk("prio_ready", 32'(tgt_ready), 32'd0);
        @(negedge clk);
        stop = 1'b0; tgt_valid = 1'b0;
        chk("prio_busy", 32'(busy), 32'd1);
        step("prio", 0, 1'b1, 1'b0);

        // Reset mid-ramp at duty 40.
        hs(60);
        for (int d = 1; d <= 40; d++) step("to60", d, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(tgt_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_duty", duty, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_tick", 32'(period_tick), 32'd0);
        #1;
        chk("mid_rel_ready", 32'(tgt_ready), 32'd1);
        count_to_tick("mid_rel_cnt");
        @(negedge clk);
        chk("mid_after_duty", duty, 32'd0);
        chk("mid_after_done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 SHALL have parameter PERIOD, default 100: period counter terminal value, so one PWM period is PERIOD+1 clk cycles.
REQ-002 SHALL have parameter STEP, default 1: duty change applied per period.
REQ-003 SHALL have parameter DMAX, default 101: upper clamp for accepted targets.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port tgt_valid  input  1  new target duty offered.
REQ-007 SHALL have port tgt_ready  output  1  controller can accept a target.
REQ-008 SHALL have port tgt_duty  input  32  requested duty, unsigned.
REQ-009 SHALL have port stop  input  1  request ramp-down to 0.
REQ-010 SHALL have port duty  output  32  registered duty value fed to the PWM generator.
REQ-011 SHALL have port busy  output  1  ramp in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on ramp completion.
REQ-013 SHALL have port period_tick  output  1  one-cycle pulse marking the period boundary.

Function
REQ-014 Period counter SHALL free-run 0..PERIOD and wrap to 0, independent of FSM state.
REQ-015 period_tick SHALL be high for exactly the cycle in which the counter equals PERIOD.
REQ-016 FSM SHALL have exactly three states: IDLE, RAMP and STOP.
REQ-017 tgt_ready SHALL equal (state==IDLE) AND NOT stop, and SHALL be 0 while rst is low.
REQ-018 Handshake SHALL occur on tgt_valid AND tgt_ready; target SHALL latch min(tgt_duty, DMAX) and state SHALL go to RAMP on that edge.
REQ-019 tgt_valid outside a handshake SHALL be ignored; the requester holds it.
REQ-020 busy SHALL be 1 exactly when state is RAMP or STOP.
REQ-021 duty SHALL change only on a clock edge where period_tick is 1, so duty never changes mid-period.
REQ-022 On each tick in RAMP, duty SHALL become min(duty+STEP, target) if duty<target, max(duty-STEP, target) if duty>target, else stay unchanged.
REQ-023 Step arithmetic SHALL use at least 33-bit intermediates, with no wrap and no underflow below target.
REQ-024 If the post-tick duty equals target, the FSM SHALL go to IDLE and done SHALL be 1 for the following cycle only.
REQ-025 A request equal to the current duty SHALL complete at the first tick after acceptance with duty unchanged.
REQ-026 stop=1 in IDLE or RAMP SHALL set target to 0 and move the FSM to STOP on that edge.
REQ-027 stop SHALL take priority over a simultaneous tgt_valid, and the target SHALL NOT be accepted.
REQ-028 In STOP, each tick SHALL set duty to max(duty-STEP, 0); when duty reaches 0 the FSM SHALL go to IDLE and pulse done.
REQ-029 stop asserted while in STOP SHALL have no effect.
REQ-030 stop in IDLE with duty=0 SHALL enter STOP and complete with done at the next tick.
REQ-031 A tick and a handshake in the same cycle SHALL only accept the target; the first step SHALL occur at the next tick.

Reset
REQ-032 While rst is low at a clock edge, the block SHALL load counter=0, duty=0, target=0, state=IDLE, done=0, busy=0 and period_tick=0.
REQ-033 Reset mid-ramp SHALL abort immediately with duty=0 the next cycle; no done pulse SHALL be issued.
REQ-034 After rst returns high, tgt_ready SHALL be 1 in the first cycle and the counter SHALL start from 0.

Verification
REQ-035 Defaults, duty=0, handshake tgt_duty=5 -> duty steps to 1,2,3,4,5 at five successive ticks 101 cycles apart; done pulses once after 5; busy and tgt_ready are restored.
REQ-036 tgt_duty=500 -> target clamped to 101; ramp ends with duty=101 and done.
REQ-037 duty=10, tgt_duty=7 -> duty goes 9,8,7 on ticks, then done; duty never drops below 7.
REQ-038 Ramp to 50 with stop asserted at duty=3 -> STOP; duty goes 2,1,0 on ticks, done pulses, tgt_ready returns to 1.
REQ-039 IDLE with stop and tgt_valid (tgt_duty=20) in the same cycle -> no handshake, STOP entered, target stays 0.
REQ-040 rst low for 1 cycle at duty=40 during ramp -> next cycle duty=0, busy=0, done=0, counter=0.
